// File: rtl/oled_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : oled_display_sequencer
//  Purpose  : Top-level PmodOLED sequencer. Steps the external init,
//             frame-driver and power-down engines through en/done
//             handshakes, routes the active engine's SPI lines to the
//             display pins, snapshots the frame before each refresh and
//             reports state, frame count and an init-timeout error.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset                       clock, async active-high reset
//    enable, mode, power_off          refresh/wake request, refresh mode,
//                                     power-down request
//    rows_in / rows_latched           live frame / snapshot to driver
//    init_en, drv_en, off_en          engine enables
//    init_done, drv_done, off_done    engine completion flags
//    init_*, drv_*, off_* (cs,sdo,sclk,dc)  engine SPI lines
//    CS, SDIN, SCLK, DC               SPI pins to the display
//    state_code, frame_count          status reporting
//    busy, error                      activity and sticky timeout flag
// ============================================================================
module oled_display_sequencer #(
  parameter int NUM_ROWS       = 4,
  parameter int ROW_BITS       = 128,
  parameter int REFRESH_DIV    = 1666667,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  input  logic                         power_off,
  input  logic [NUM_ROWS*ROW_BITS-1:0] rows_in,
  output logic [NUM_ROWS*ROW_BITS-1:0] rows_latched,
  output logic                         init_en,
  output logic                         drv_en,
  output logic                         off_en,
  input  logic                         init_done,
  input  logic                         drv_done,
  input  logic                         off_done,
  input  logic                         init_cs,
  input  logic                         init_sdo,
  input  logic                         init_sclk,
  input  logic                         init_dc,
  input  logic                         drv_cs,
  input  logic                         drv_sdo,
  input  logic                         drv_sclk,
  input  logic                         drv_dc,
  input  logic                         off_cs,
  input  logic                         off_sdo,
  input  logic                         off_sclk,
  input  logic                         off_dc,
  output logic                         CS,
  output logic                         SDIN,
  output logic                         SCLK,
  output logic                         DC,
  output logic [3:0]                   state_code,
  output logic [15:0]                  frame_count,
  output logic                         busy,
  output logic                         error
);

  localparam int FRAME_W = NUM_ROWS * ROW_BITS;
  localparam int RT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [RT_W-1:0] RT_MAX = RT_W'(REFRESH_DIV - 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_READY    = 4'd2,
    ST_LATCH    = 4'd3,
    ST_DRIVE    = 4'd4,
    ST_HOLD     = 4'd5,
    ST_SHUTDOWN = 4'd6,
    ST_OFF      = 4'd7,
    ST_FAULT    = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d;            // init watchdog
  logic [RT_W-1:0]      rt_q, rt_d;            // refresh timer
  logic                 mode_q, mode_d;        // mode captured in READY
  logic [FRAME_W-1:0]   rows_latched_q, rows_latched_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 error_q, error_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wd_q           <= '0;
      rt_q           <= '0;
      mode_q         <= 1'b0;
      rows_latched_q <= '0;
      frame_count_q  <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      rt_q           <= rt_d;
      mode_q         <= mode_d;
      rows_latched_q <= rows_latched_d;
      frame_count_q  <= frame_count_d;
      error_q        <= error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    wd_d           = wd_q;
    mode_d         = mode_q;
    rows_latched_d = rows_latched_q;
    frame_count_d  = frame_count_q;
    error_d        = error_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_INIT;
        wd_d    = '0;
      end

      ST_INIT: begin
        // A done flag on the final watchdog cycle still counts as success.
        if (init_done) begin
          state_d = ST_READY;
        end else if (wd_q == WD_MAX) begin
          state_d = ST_FAULT;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      ST_READY: begin
        mode_d = mode;
        if (power_off) begin
          state_d = ST_SHUTDOWN;
        end else if ((!mode && (rt_q >= RT_MAX)) || (mode && enable)) begin
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        rows_latched_d = rows_in;
        state_d        = ST_DRIVE;
      end

      ST_DRIVE: begin
        if (drv_done) begin
          state_d       = ST_HOLD;
          frame_count_d = frame_count_q + 16'd1;
        end
      end

      ST_HOLD: begin
        // In on-demand mode the request level must drop before another
        // frame may start, so one request yields exactly one frame.
        if (!drv_done && (!mode_q || !enable)) begin
          state_d = ST_READY;
        end
      end

      ST_SHUTDOWN: begin
        if (off_done) begin
          state_d = ST_OFF;
        end
      end

      ST_OFF: begin
        if (!power_off && enable) begin
          state_d = ST_INIT;
          wd_d    = '0;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Refresh timer restarts on the cycle LATCH is entered and saturates so the
  // first mode-0 frame after a long init starts on the first READY cycle.
  always_comb begin
    rt_d = rt_q;
    if (state_d == ST_LATCH) begin
      rt_d = '0;
    end else if (rt_q < RT_MAX) begin
      rt_d = rt_q + RT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from the state register
  // --------------------------------------------------------------------------
  always_comb begin
    init_en = (state_q == ST_INIT);
    drv_en  = (state_q == ST_DRIVE);
    off_en  = (state_q == ST_SHUTDOWN);
    busy    = !((state_q == ST_READY) || (state_q == ST_OFF) ||
                (state_q == ST_FAULT));

    // Idle bus: chip deselected, clock parked high.
    CS   = 1'b1;
    SDIN = 1'b0;
    SCLK = 1'b1;
    DC   = 1'b0;
    case (state_q)
      ST_INIT: begin
        CS   = init_cs;
        SDIN = init_sdo;
        SCLK = init_sclk;
        DC   = init_dc;
      end
      ST_DRIVE, ST_HOLD: begin
        CS   = drv_cs;
        SDIN = drv_sdo;
        SCLK = drv_sclk;
        DC   = drv_dc;
      end
      ST_SHUTDOWN: begin
        CS   = off_cs;
        SDIN = off_sdo;
        SCLK = off_sclk;
        DC   = off_dc;
      end
      default: begin
        CS   = 1'b1;
        SDIN = 1'b0;
        SCLK = 1'b1;
        DC   = 1'b0;
      end
    endcase
  end

  assign state_code   = state_q;
  assign rows_latched = rows_latched_q;
  assign frame_count  = frame_count_q;
  assign error        = error_q;

endmodule
`default_nettype wire

// File: doc/oled_display_sequencer.md
Name: oled_display_sequencer

Overview:
- Next-generation top-level PmodOLED sequencer. Sequences the external init, frame-driver and power-down engines through en/done handshakes.
- Routes the active engine's SPI signals (CS, SDIN, SCLK, DC) to the pins.
- Adds over the previous controller: parametrised row count, a frame snapshot buffer, continuous and on-demand refresh modes, a power-down/re-init path, an init watchdog, and frame/status reporting.

Parameters:
- NUM_ROWS, 4: text rows (pages) per frame.
- ROW_BITS, 128: bits per row.
- REFRESH_DIV, 1666667: minimum cycles between frame starts in continuous mode (60 Hz at 100 MHz); must be >= 2.
- TIMEOUT_CYCLES, 2000000: init watchdog limit in cycles.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  refresh request (mode 1) / wake request from OFF.
- mode  in  1  0 = continuous refresh, 1 = on-demand refresh.
- power_off  in  1  request display power-down.
- rows_in  in  NUM_ROWS*ROW_BITS  live frame content; row 0 in the MSBs.
- rows_latched  out  NUM_ROWS*ROW_BITS  stable frame snapshot fed to the driver.
- init_en / drv_en / off_en  out  1 each  engine enables.
- init_done / drv_done / off_done  in  1 each  engine completion flags.
- init_cs, init_sdo, init_sclk, init_dc  in  1 each  init engine SPI signals.
- drv_cs, drv_sdo, drv_sclk, drv_dc  in  1 each  driver engine SPI signals.
- off_cs, off_sdo, off_sclk, off_dc  in  1 each  power-down engine SPI signals.
- CS, SDIN, SCLK, DC  out  1 each  SPI pins to the display.
- state_code  out  4  encoded current state.
- frame_count  out  16  completed frames.
- busy  out  1  high in any state except READY, OFF and FAULT.
- error  out  1  sticky init-timeout flag.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Assertion forces every register to its reset value immediately, with no clock edge required.
- Reset values: state IDLE, state_code 0, all en outputs 0, rows_latched 0, frame_count 0, error 0, busy 1, timers 0.
- State codes: IDLE 0, INIT 1, READY 2, LATCH 3, DRIVE 4, HOLD 5, SHUTDOWN 6, OFF 7, FAULT 8.
- en outputs are decoded from the state register:
  - init_en is high only in INIT.
  - drv_en is high only in DRIVE.
  - off_en is high only in SHUTDOWN.
- SPI mux is combinational from the state register:
  - INIT routes init_*; DRIVE and HOLD route drv_*; SHUTDOWN routes off_*.
  - All other states drive CS=1, SDIN=0, SCLK=1, DC=0.
- IDLE: goes to INIT on the next cycle. The watchdog clears on entering INIT.
- INIT: init_done=1 moves to READY.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1, the block moves to FAULT and sets error=1.
  - If init_done and the timeout coincide, init_done wins.
- READY: priority is power_off, then refresh.
  - power_off=1 moves to SHUTDOWN.
  - Otherwise, move to LATCH when either:
    - mode=0 and refresh timer >= REFRESH_DIV-1, or
    - mode=1 and enable=1.
  - mode is sampled only in READY.
- LATCH: exactly one cycle. rows_latched <= rows_in, then move to DRIVE. rows_latched is constant at all other times.
- DRIVE: drv_done=1 moves to HOLD and increments frame_count; 0xFFFF wraps to 0x0000.
- HOLD: drv_en=0. Return to READY when drv_done=0 and (mode=0 or enable=0), so each mode-1 request level yields exactly one frame.
- Refresh timer: clears on entering LATCH, increments every cycle elsewhere, saturates at REFRESH_DIV-1. The first frame after INIT therefore starts at the first READY cycle in mode 0.
- power_off during LATCH, DRIVE or HOLD is not acted on until READY; the frame in flight always completes.
- SHUTDOWN: off_done=1 moves to OFF.
- OFF: when power_off=0 and enable=1, move to INIT for a full re-init. frame_count is retained.
- FAULT: terminal; only reset exits.
- Engine done inputs arriving in states that do not wait on them are ignored.

Test Plan:
- Reset then init_done pulsed at cycle 10 → init_en high on cycles 1-10, state_code 2 on cycle 11. With mode=0, rows_latched equals rows_in one cycle after LATCH.
- Mode 0, REFRESH_DIV=20, drv_done returned 5 cycles after drv_en → LATCH entries exactly 20 cycles apart; frame_count counts 1, 2, 3.
- Mode 1, enable held high across 3 driver completions → exactly one frame. Drop enable, raise again → second frame; frame_count=2.
- power_off raised mid-DRIVE → frame completes and frame_count increments, then SHUTDOWN routes off_* to the pins. OFF drives CS=1. enable=1 with power_off=0 → INIT re-entered.
- TIMEOUT_CYCLES=50, init_done never asserted → FAULT at cycle 51 with error=1 and CS=1. Later done pulses are ignored; only reset clears.
- reset asserted mid-DRIVE between clock edges → drv_en=0, CS=1, frame_count=0 immediately; after release, init_en rises within 2 cycles.
